// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_tx8 serial transmitter.
package piso_pkg;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_t;
endpackage

// File: rtl/piso_bit_counter.sv
// Counts transmitted bits; last flags the final bit of a WIDTH-bit frame.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic Re,
  input  logic en,
  input  logic clr,
  output logic last
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/piso_tx8.sv
// Parallel-in/serial-out transmitter: shifts a WIDTH-bit word out LSB first,
// one bit per cycle with sEn high, into a shift-right receiver (serial in at MSB).
module piso_tx8
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             Re,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             pause,
  output logic             sOut,
  output logic             sEn,
  output logic             busy,
  output logic             done
);
  // state | meaning
  // IDLE  | waiting for a word; load_ready high
  // SHIFT | presenting shreg[0]; shifts on every cycle pause is low
  // DONE  | one-cycle done pulse after the last bit, then back to IDLE

  tx_state_t        state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             shift_en;
  logic             last;

  assign accept   = (state == IDLE) && load_valid;
  assign shift_en = (state == SHIFT) && !pause;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk  (clk),
    .Re   (Re),
    .en   (shift_en),
    .clr  (accept),
    .last (last)
  );

  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (shift_en && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    sOut       = 1'b0;
    sEn        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        sOut = shreg[0];
        sEn  = !pause;
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // Zero fill keeps shreg clean once the frame has drained.
  always_ff @(posedge clk or negedge Re) begin
    if (!Re) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= din;
    end else if (shift_en) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end
endmodule

// File: tb/tb_piso_tx8.sv
// Bench for piso_tx8: scoreboard of expected serial bits and words, checked against a receiver model.
module tb_piso_tx8;
  logic       clk = 1'b0;
  logic       Re = 1'b0;
  logic       load_valid = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] din = 8'h00;
  logic       load_ready, sOut, sEn, busy, done;

  logic [7:0] rx_q;
  logic       exp_q[$];
  logic [7:0] word_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  piso_tx8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .Re         (Re),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .pause      (pause),
    .sOut       (sOut),
    .sEn        (sEn),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Receiver: 8-bit shift-right register, serial in at MSB, shifts only when sEn.
  always @(posedge clk or negedge Re) begin
    if (!Re) rx_q <= 8'h00;
    else if (sEn) rx_q <= {sOut, rx_q[7:1]};
  end

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    word_q.push_back(w);
  endtask

  task automatic test_reset();
    Re = 1'b0;
    #2;
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", load_ready); else pass_cnt++;
    total_cnt++; if (sEn !== 1'b0) $display("FAIL reset_sen: got %b want 0", sEn); else pass_cnt++;
    total_cnt++; if (sOut !== 1'b0) $display("FAIL reset_sout: got %b want 0", sOut); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
    @(negedge clk);
    Re = 1'b1;
  endtask

  task automatic test_idle_pause();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      pause = 1'b1;
      #1;
      total_cnt++; if (sEn !== 1'b0) $display("FAIL idle_pause_sen: got %b want 0", sEn); else pass_cnt++;
      total_cnt++; if (load_ready !== 1'b1 || busy !== 1'b0) $display("FAIL idle_pause_state: got ready=%b busy=%b want ready=1 busy=0", load_ready, busy); else pass_cnt++;
    end
    @(negedge clk);
    pause = 1'b0;
  endtask

  task automatic test_basic(input logic [7:0] w);
    int   cyc;
    int   nbits;
    logic e;
    nbits = 0;
    @(negedge clk);
    load_valid = 1'b1; din = w;
    #1;
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", load_ready); else pass_cnt++;
    push_word(w);
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin load_valid = 1'b0; din = 8'h00; end
      #1;
      if (sEn === 1'b1) begin
        nbits++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL basic_bit: got %b want no bit", sOut);
        else begin
          e = exp_q.pop_front();
          if (sOut !== e) $display("FAIL basic_bit%0d: got %b want %b", nbits - 1, sOut, e); else pass_cnt++;
        end
      end
      if (done === 1'b1) break;
    end
    total_cnt++; if (cyc != 9) $display("FAIL basic_done_cycle: got k+%0d want k+9", cyc); else pass_cnt++;
    total_cnt++; if (nbits != 8) $display("FAIL basic_bit_count: got %0d want 8", nbits); else pass_cnt++;
    total_cnt++;
    if (word_q.size() == 0) $display("FAIL basic_rx: got %h want no word", rx_q);
    else begin
      e = 1'b0;
      if (rx_q !== word_q[0]) $display("FAIL basic_rx: got %h want %h", rx_q, word_q[0]); else pass_cnt++;
      void'(word_q.pop_front());
    end
    @(negedge clk);
    #1;
    total_cnt++; if (load_ready !== 1'b1 || done !== 1'b0) $display("FAIL basic_back_idle: got ready=%b done=%b want ready=1 done=0", load_ready, done); else pass_cnt++;
  endtask

  task automatic test_pause();
    int   cyc;
    logic e;
    @(negedge clk);
    load_valid = 1'b1; din = 8'h3C;
    #1;
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL pause_ready: got %b want 1", load_ready); else pass_cnt++;
    push_word(8'h3C);
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin load_valid = 1'b0; din = 8'h00; end
      pause = (cyc >= 3 && cyc <= 5);
      #1;
      if (pause) begin
        total_cnt++; if (sEn !== 1'b0 || sOut !== 1'b1) $display("FAIL pause_hold: got sEn=%b sOut=%b want sEn=0 sOut=1", sEn, sOut); else pass_cnt++;
      end
      if (sEn === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL pause_bit: got %b want no bit", sOut);
        else begin
          e = exp_q.pop_front();
          if (sOut !== e) $display("FAIL pause_bit: got %b want %b at k+%0d", sOut, e, cyc); else pass_cnt++;
        end
      end
      if (done === 1'b1) break;
    end
    pause = 1'b0;
    total_cnt++; if (cyc != 12) $display("FAIL pause_done_cycle: got k+%0d want k+12", cyc); else pass_cnt++;
    total_cnt++;
    if (word_q.size() == 0) $display("FAIL pause_rx: got %h want no word", rx_q);
    else if (rx_q !== word_q.pop_front()) $display("FAIL pause_rx: got %h want 3c", rx_q);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    int   cyc;
    logic e;
    @(negedge clk);
    load_valid = 1'b1; din = 8'h01;
    #1;
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL ignore_ready: got %b want 1", load_ready); else pass_cnt++;
    push_word(8'h01);
    for (cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) din = 8'hFF;
      #1;
      if (sEn === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL ignore_bit: got %b want no bit", sOut);
        else begin
          e = exp_q.pop_front();
          if (sOut !== e) $display("FAIL ignore_bit: got %b want %b at k+%0d", sOut, e, cyc); else pass_cnt++;
        end
      end
      if (done === 1'b1) break;
    end
    total_cnt++; if (cyc != 9) $display("FAIL ignore_done_cycle: got k+%0d want k+9", cyc); else pass_cnt++;
    total_cnt++;
    if (word_q.size() == 0) $display("FAIL ignore_rx: got %h want no word", rx_q);
    else if (rx_q !== word_q.pop_front()) $display("FAIL ignore_rx: got %h want 01", rx_q);
    else pass_cnt++;
    @(negedge clk);
    load_valid = 1'b0; din = 8'h00;
    #1;
    total_cnt++; if (load_ready !== 1'b1 || busy !== 1'b0) $display("FAIL ignore_idle: got ready=%b busy=%b want ready=1 busy=0", load_ready, busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int   cyc;
    int   nd;
    bit   second;
    logic e;
    nd = 0;
    second = 1'b0;
    @(negedge clk);
    load_valid = 1'b1; din = 8'h81;
    #1;
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", load_ready); else pass_cnt++;
    push_word(8'h81);
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) din = 8'h7E;
      if (second) load_valid = 1'b0;
      #1;
      if (load_ready === 1'b1 && !second) begin
        second = 1'b1;
        push_word(8'h7E);
        total_cnt++; if (cyc != 10) $display("FAIL b2b_second_accept: got k+%0d want k+10", cyc); else pass_cnt++;
      end
      if (sEn === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_bit: got %b want no bit", sOut);
        else begin
          e = exp_q.pop_front();
          if (sOut !== e) $display("FAIL b2b_bit: got %b want %b at k+%0d", sOut, e, cyc); else pass_cnt++;
        end
      end
      if (done === 1'b1) begin
        nd++;
        total_cnt++; if (cyc != ((nd == 1) ? 9 : 19)) $display("FAIL b2b_done_cycle: got k+%0d want k+%0d", cyc, (nd == 1) ? 9 : 19); else pass_cnt++;
        total_cnt++;
        if (word_q.size() == 0) $display("FAIL b2b_rx: got %h want no word", rx_q);
        else begin
          if (rx_q !== word_q[0]) $display("FAIL b2b_rx: got %h want %h", rx_q, word_q[0]); else pass_cnt++;
          void'(word_q.pop_front());
        end
        if (nd == 2) break;
      end
    end
    load_valid = 1'b0;
    total_cnt++; if (nd != 2) $display("FAIL b2b_frames: got %0d want 2", nd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    load_valid = 1'b1; din = 8'hC3;
    #1;
    total_cnt++; if (load_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", load_ready); else pass_cnt++;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      load_valid = 1'b0; din = 8'h00;
    end
    #1;
    total_cnt++; if (sEn !== 1'b1 || busy !== 1'b1) $display("FAIL rstmid_pre: got sEn=%b busy=%b want 1 1", sEn, busy); else pass_cnt++;
    @(negedge clk);
    Re = 1'b0;
    #1;
    total_cnt++; if (sEn !== 1'b0 || sOut !== 1'b0) $display("FAIL rstmid_serial: got sEn=%b sOut=%b want 0 0", sEn, sOut); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || load_ready !== 1'b1) $display("FAIL rstmid_state: got busy=%b ready=%b want 0 1", busy, load_ready); else pass_cnt++;
    exp_q.delete();
    word_q.delete();
    @(negedge clk);
    Re = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      total_cnt++; if (done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1) $display("FAIL rstmid_after: got done=%b busy=%b ready=%b want 0 0 1", done, busy, load_ready); else pass_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle_pause();
    test_basic(8'hA5);
    test_pause();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_basic(8'h96);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
